// File: rtl/rsa_pkg.sv
// Shared command codes and sequencer states for the RSA host front end
// and the exponentiation controller.
package rsa_pkg;

    typedef enum logic [2:0] {
        CMD_NONE = 3'd0,
        CMD_DATA = 3'd1,
        CMD_E    = 3'd2,
        CMD_N    = 3'd3
    } cmd_t;

    typedef enum logic [1:0] {
        KIND_RSVD = 2'd0,
        KIND_DATA = 2'd1,
        KIND_E    = 2'd2,
        KIND_N    = 2'd3
    } req_kind_t;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_GAP   = 3'd2,
        S_BUSY  = 3'd3,
        S_RESP  = 3'd4,
        S_FAULT = 3'd5
    } seq_state_t;

endpackage

// File: rtl/watchdog_counter.sv
// Counts enabled cycles; flags expiry on the TIMEOUT-th enabled cycle.
// Clear has priority so the count restarts from 0 on every wait.
module watchdog_counter #(
    parameter int TIMEOUT = 4096
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] count;

    // Cycle counter, held at zero while cleared.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CW'(1);
        end
    end

    assign expired = enable && (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/rsa_host_sequencer.sv
// Host-side sequencer for the modexp core: issues one spaced command per
// request, waits for done with a watchdog, and returns one response.
module rsa_host_sequencer
    import rsa_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 4096
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_kind,
    input  logic [WIDTH-1:0] req_value,
    output logic [2:0]       input_data_type,
    output logic [WIDTH-1:0] operand,
    input  logic             core_done,
    input  logic [WIDTH-1:0] core_result,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_error,
    output logic [1:0]       keys_loaded
);

    seq_state_t state;
    seq_state_t state_n;
    logic [1:0] kind_q;
    logic       fault_q;
    logic       accept;
    logic       req_ok;
    logic       expired;

    assign accept = (state == S_IDLE) && req_valid;
    assign req_ok = (req_kind == KIND_E) || (req_kind == KIND_N) ||
                    ((req_kind == KIND_DATA) && (keys_loaded == 2'b11));

    assign req_ready       = (state == S_IDLE);
    assign rsp_valid       = (state == S_RESP);
    assign input_data_type = (state == S_ISSUE) ? {1'b0, kind_q} : CMD_NONE;

    watchdog_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (state != S_BUSY),
        .enable  (state == S_BUSY),
        .expired (expired)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state logic; keys skip BUSY, DATA skips GAP.
    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE: begin
                if (req_valid) begin
                    state_n = req_ok ? S_ISSUE : S_RESP;
                end
            end
            S_ISSUE: begin
                state_n = (kind_q == KIND_DATA) ? S_BUSY : S_GAP;
            end
            S_GAP: begin
                state_n = S_RESP;
            end
            S_BUSY: begin
                if (core_done || expired) begin
                    state_n = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_n = fault_q ? S_FAULT : S_IDLE;
                end
            end
            S_FAULT: begin
                state_n = S_FAULT;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // Request latch, key flags and response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            kind_q      <= 2'd0;
            operand     <= '0;
            rsp_data    <= '0;
            rsp_error   <= 1'b0;
            keys_loaded <= 2'b00;
            fault_q     <= 1'b0;
        end else begin
            if (accept) begin
                kind_q  <= req_kind;
                operand <= req_value;
                if (!req_ok) begin
                    rsp_data  <= '0;
                    rsp_error <= 1'b1;
                end
            end
            if ((state == S_ISSUE) && (kind_q != KIND_DATA)) begin
                if (kind_q == KIND_E) begin
                    keys_loaded[0] <= 1'b1;
                end else begin
                    keys_loaded[1] <= 1'b1;
                end
                rsp_data  <= operand;
                rsp_error <= 1'b0;
            end
            if (state == S_BUSY) begin
                if (core_done) begin
                    rsp_data  <= core_result;
                    rsp_error <= 1'b0;
                end else if (expired) begin
                    rsp_data  <= '0;
                    rsp_error <= 1'b1;
                    fault_q   <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_rsa_host_sequencer.sv
// Directed plus randomized bench for rsa_host_sequencer with a
// request-level reference model of latency, response and key flags.
module tb_rsa_host_sequencer;

    localparam int W  = 32;
    localparam int TO = 48;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [1:0]   req_kind = 2'd0;
    logic [W-1:0] req_value = '0;
    logic [2:0]   input_data_type;
    logic [W-1:0] operand;
    logic         core_done = 1'b0;
    logic [W-1:0] core_result = '0;
    logic         rsp_valid;
    logic         rsp_ready = 1'b0;
    logic [W-1:0] rsp_data;
    logic         rsp_error;
    logic [1:0]   keys_loaded;

    int   ncmp  = 0;
    int   nfail = 0;
    logic [1:0] m_keys = 2'b00;

    rsa_host_sequencer #(
        .WIDTH   (W),
        .TIMEOUT (TO)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_kind        (req_kind),
        .req_value       (req_value),
        .input_data_type (input_data_type),
        .operand         (operand),
        .core_done       (core_done),
        .core_result     (core_result),
        .rsp_valid       (rsp_valid),
        .rsp_ready       (rsp_ready),
        .rsp_data        (rsp_data),
        .rsp_error       (rsp_error),
        .keys_loaded     (keys_loaded)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_req_ready"}, req_ready, 1);
        chk({tag, "_idt"}, input_data_type, 0);
        chk({tag, "_operand"}, operand, 0);
        chk({tag, "_rsp_valid"}, rsp_valid, 0);
        chk({tag, "_rsp_data"}, rsp_data, 0);
        chk({tag, "_rsp_error"}, rsp_error, 0);
        chk({tag, "_keys"}, keys_loaded, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        core_done = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_keys = 2'b00;
        chk_reset_vals("reset");
    endtask

    // lat: BUSY cycle on which the core pulses done (0 = never).
    task automatic do_req(input logic [1:0] kind, input logic [W-1:0] value,
                          input int lat, input logic [W-1:0] res,
                          input int hold);
        int           exp_n;
        logic [W-1:0] exp_d;
        logic         exp_e;
        logic [2:0]   exp_cmd;
        bit           flt;
        int           n;
        int           issues;
        int           issue_n;
        logic [2:0]   got_cmd;
        logic [W-1:0] held;
        flt = 0;
        if (kind == 2'd0 || (kind == 2'd1 && m_keys != 2'b11)) begin
            exp_n = 1; exp_d = '0; exp_e = 1; exp_cmd = 3'd0;
        end else if (kind != 2'd1) begin
            exp_n = 3; exp_d = value; exp_e = 0; exp_cmd = {1'b0, kind};
            if (kind == 2'd2) m_keys[0] = 1'b1;
            else m_keys[1] = 1'b1;
        end else if (lat >= 1 && lat <= TO) begin
            exp_n = lat + 2; exp_d = res; exp_e = 0; exp_cmd = 3'd1;
        end else begin
            exp_n = TO + 2; exp_d = '0; exp_e = 1; exp_cmd = 3'd1; flt = 1;
        end

        @(negedge clk);
        chk("req_ready_idle", req_ready, 1);
        req_valid = 1'b1;
        req_kind  = kind;
        req_value = value;
        @(negedge clk);
        req_valid = 1'b0;
        req_kind  = 2'($urandom);
        req_value = $urandom;
        n = 1; issues = 0; issue_n = 0; got_cmd = 3'd0;
        while (!rsp_valid && n <= TO + 8) begin
            if (input_data_type != 3'd0) begin
                issues++;
                got_cmd = input_data_type;
                issue_n = n;
            end
            core_result = $urandom;
            if (exp_cmd == 3'd1 && lat != 0 && n - 1 == lat) begin
                core_done   = 1'b1;
                core_result = res;
            end else if (n == 1 || (exp_cmd != 3'd1 && n == 2)) begin
                core_done = 1'($urandom);
            end else begin
                core_done = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        core_done = 1'b0;
        chk("rsp_latency", n, exp_n);
        if (!rsp_valid) begin
            do_reset();
            return;
        end
        chk("idt_in_resp", input_data_type, 0);
        chk("issue_count", issues, (exp_cmd != 3'd0) ? 1 : 0);
        chk("issue_cmd", got_cmd, exp_cmd);
        chk("issue_cycle", issue_n, (exp_cmd != 3'd0) ? 1 : 0);
        chk("rsp_data", rsp_data, exp_d);
        chk("rsp_error", rsp_error, exp_e);
        chk("keys_loaded", keys_loaded, m_keys);
        chk("operand_hold", operand, value);
        chk("req_ready_resp", req_ready, 0);
        held = rsp_data;
        for (int i = 0; i < hold; i++) begin
            core_done   = 1'($urandom);
            core_result = $urandom;
            req_valid   = 1'($urandom);
            @(negedge clk);
            chk("hold_valid", rsp_valid, 1);
            chk("hold_data", rsp_data, held);
            chk("hold_error", rsp_error, exp_e);
            chk("hold_req_ready", req_ready, 0);
        end
        core_done = 1'b0;
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("post_hs_valid", rsp_valid, 0);
        chk("post_hs_ready", req_ready, flt ? 0 : 1);
        if (flt) begin
            for (int i = 0; i < 3; i++) begin
                req_valid = 1'b1;
                req_kind  = 2'd2;
                @(negedge clk);
                chk("fault_req_ready", req_ready, 0);
                chk("fault_rsp_valid", rsp_valid, 0);
                chk("fault_idt", input_data_type, 0);
            end
            req_valid = 1'b0;
            do_reset();
        end
    endtask

    initial begin
        int           k;
        int           lat;
        logic [W-1:0] v;
        do_reset();
        do_req(2'd1, 32'h41, 10, 32'h0, 0);
        do_req(2'd2, 32'h10001, 0, 32'h0, 0);
        do_req(2'd3, 32'hC5, 0, 32'h0, 0);
        do_req(2'd1, 32'h41, 40, 32'h2A, 10);
        do_req(2'd1, 32'h55, 0, 32'h0, 2);
        do_req(2'd2, 32'h3, 0, 32'h0, 0);
        do_req(2'd3, 32'hF1, 0, 32'h0, 0);
        do_req(2'd1, 32'h77, TO, 32'hBEEF, 0);
        do_req(2'd1, 32'h78, 1, 32'h1234, 0);
        do_req(2'd0, 32'h99, 0, 32'h0, 3);

        // Reset while waiting on the core.
        @(negedge clk);
        req_valid = 1'b1;
        req_kind  = 2'd1;
        req_value = 32'h42;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_keys = 2'b00;
        chk_reset_vals("mid_busy_rst");
        do_req(2'd3, 32'hABCD, 0, 32'h0, 0);

        for (int i = 0; i < 40; i++) begin
            k = int'($urandom_range(0, 9));
            v = $urandom;
            lat = int'($urandom_range(1, TO));
            if ($urandom_range(0, 9) == 0) lat = 0;
            if (k < 3) do_req(2'd2, v, 0, 32'h0, int'($urandom_range(0, 3)));
            else if (k < 5) do_req(2'd3, v, 0, 32'h0, int'($urandom_range(0, 3)));
            else if (k == 5) do_req(2'd0, v, 0, 32'h0, 1);
            else do_req(2'd1, v, lat, $urandom, int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
